// File: rtl/parking_pkg.sv
// parking_pkg: shared definitions for the parking lot controllers.
//   SLOTS / TIME_W  - occupancy map width and timestamp width
//   slot_t          - slot index type
//   state_t         - exit gate controller states
//   exit_req_t      - exit request latched in IDLE
//   decode_token()  - token -> slot; XOR is its own inverse, so the
//                     producer uses the same function
package parking_pkg;

    localparam int SLOTS  = 8;
    localparam int TIME_W = 8;
    localparam int SLOT_W = $clog2(SLOTS);
    localparam int CNT_W  = $clog2(SLOTS + 1);

    typedef logic [SLOT_W-1:0] slot_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_CHARGE,
        ST_GATE,
        ST_ERROR
    } state_t;

    typedef struct packed {
        slot_t             slot;
        logic [TIME_W-1:0] time_in;
        logic [TIME_W-1:0] time_out;
    } exit_req_t;

    function automatic slot_t decode_token(input slot_t token, input slot_t pattern);
        return token ^ pattern;
    endfunction

endpackage

// File: rtl/slot_counter.sv
// slot_counter: popcount of the occupancy map.
//   occupancy - bit i set when slot i is occupied
//   parked    - number of occupied slots
//   empty     - SLOTS - parked
module slot_counter
    import parking_pkg::*;
(
    input  logic [SLOTS-1:0] occupancy,
    output logic [CNT_W-1:0] parked,
    output logic [CNT_W-1:0] empty
);

    logic [CNT_W-1:0] cnt;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < SLOTS; i++)
            cnt = cnt + CNT_W'(occupancy[i]);
    end

    assign parked = cnt;
    assign empty  = CNT_W'(SLOTS) - cnt;

endmodule

// File: rtl/parking_exit_gate.sv
// parking_exit_gate: exit-side controller. Decodes the driver token to a
// slot, checks it is occupied, charges the stay, frees the slot and holds
// the barrier open for GATE_OPEN_CYCLES cycles. Owns the occupancy map.
//   clk, rst               - clock, async active-high reset
//   capacity_in/_load      - occupancy map load from entry side (IDLE only)
//   exit_req, token,
//   pattern, time_in/out   - exit request (sampled in IDLE only)
//   new_capacity           - occupancy register
//   time_total, fee        - result of last successful exit
//   exit_ack / exit_err    - one-cycle success / empty-slot pulses
//   gate_open, busy        - barrier open, controller not idle
//   parked, empty          - occupied / free slot counts
module parking_exit_gate
    import parking_pkg::*;
#(
    parameter int FEE_RATE         = 2,
    parameter int GATE_OPEN_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SLOTS-1:0]  capacity_in,
    input  logic              capacity_load,
    input  logic              exit_req,
    input  slot_t             token,
    input  slot_t             pattern,
    input  logic [TIME_W-1:0] time_in,
    input  logic [TIME_W-1:0] time_out,
    output logic [SLOTS-1:0]  new_capacity,
    output logic [TIME_W-1:0] time_total,
    output logic [15:0]       fee,
    output logic              exit_ack,
    output logic              exit_err,
    output logic              gate_open,
    output logic              busy,
    output logic [CNT_W-1:0]  parked,
    output logic [CNT_W-1:0]  empty
);

    localparam int GATE_W = $clog2(GATE_OPEN_CYCLES) + 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_OPEN_CYCLES - 1);

    state_t            state_q, state_d;
    exit_req_t         req_q;
    logic [SLOTS-1:0]  occ_q;
    logic [TIME_W-1:0] time_total_q;
    logic [15:0]       fee_q;
    logic [GATE_W-1:0] gate_cnt_q;

    logic [TIME_W-1:0] stay;
    logic [15:0]       fee_calc;

    // Modular subtraction makes a rollover between entry and exit legal.
    assign stay     = req_q.time_out - req_q.time_in;
    assign fee_calc = 16'(stay) * 16'(FEE_RATE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (exit_req) state_d = ST_CHECK;
            ST_CHECK:  state_d = occ_q[req_q.slot] ? ST_CHARGE : ST_ERROR;
            ST_CHARGE: state_d = ST_GATE;
            ST_GATE:   if (gate_cnt_q == '0) state_d = ST_IDLE;
            ST_ERROR:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q        <= '0;
            occ_q        <= '0;
            time_total_q <= '0;
            fee_q        <= '0;
            gate_cnt_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // A load and a request in the same cycle both land, so
                    // CHECK sees the freshly loaded map.
                    if (capacity_load) occ_q <= capacity_in;
                    if (exit_req)
                        req_q <= '{slot:     decode_token(token, pattern),
                                   time_in:  time_in,
                                   time_out: time_out};
                end
                ST_CHARGE: begin
                    occ_q[req_q.slot] <= 1'b0;
                    time_total_q      <= stay;
                    fee_q             <= fee_calc;
                    gate_cnt_q        <= GATE_LAST;
                end
                ST_GATE: if (gate_cnt_q != '0) gate_cnt_q <= gate_cnt_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Strobes decode straight from the state register so they fall the
    // instant reset asserts.
    assign gate_open    = (state_q == ST_GATE);
    assign exit_ack     = (state_q == ST_GATE) && (gate_cnt_q == GATE_LAST);
    assign exit_err     = (state_q == ST_ERROR);
    assign busy         = (state_q != ST_IDLE);
    assign new_capacity = occ_q;
    assign time_total   = time_total_q;
    assign fee          = fee_q;

    slot_counter u_slot_counter (
        .occupancy (occ_q),
        .parked    (parked),
        .empty     (empty)
    );

endmodule

// File: tb/tb_parking_exit_gate.sv
// tb_parking_exit_gate: directed self-checking bench for parking_exit_gate.
module tb_parking_exit_gate;
    import parking_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [SLOTS-1:0]  capacity_in = '0;
    logic              capacity_load = 1'b0;
    logic              exit_req = 1'b0;
    slot_t             token = '0;
    slot_t             pattern = '0;
    logic [TIME_W-1:0] time_in = '0;
    logic [TIME_W-1:0] time_out = '0;
    logic [SLOTS-1:0]  new_capacity;
    logic [TIME_W-1:0] time_total;
    logic [15:0]       fee;
    logic              exit_ack, exit_err, gate_open, busy;
    logic [CNT_W-1:0]  parked, empty;

    int n_chk = 0;
    int n_err = 0;

    parking_exit_gate #(.FEE_RATE(2), .GATE_OPEN_CYCLES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .capacity_in   (capacity_in),
        .capacity_load (capacity_load),
        .exit_req      (exit_req),
        .token         (token),
        .pattern       (pattern),
        .time_in       (time_in),
        .time_out      (time_out),
        .new_capacity  (new_capacity),
        .time_total    (time_total),
        .fee           (fee),
        .exit_ack      (exit_ack),
        .exit_err      (exit_err),
        .gate_open     (gate_open),
        .busy          (busy),
        .parked        (parked),
        .empty         (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_map(input logic [SLOTS-1:0] m);
        capacity_in   = m;
        capacity_load = 1'b1;
        tick();
        capacity_load = 1'b0;
    endtask

    // Issues one exit request (optionally with a same-cycle map load) and
    // watches 10 cycles. Index 1 is the cycle right after the sampling edge.
    // inj > 0 fires a second request plus an 8'hFF load at that index.
    task automatic do_exit(input slot_t tk, input slot_t pt,
                           input logic [7:0] tin, input logic [7:0] tout,
                           input logic ld, input logic [7:0] ld_val, input int inj,
                           output int g, output int a, output int e,
                           output int fa, output int fe);
        g = 0; a = 0; e = 0; fa = 0; fe = 0;
        token = tk; pattern = pt; time_in = tin; time_out = tout;
        capacity_in = ld_val; capacity_load = ld;
        exit_req = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            exit_req = 1'b0;
            capacity_load = 1'b0;
            if (i == inj) begin
                exit_req = 1'b1; capacity_load = 1'b1; capacity_in = 8'hFF;
            end
            if (gate_open) g++;
            if (exit_ack) begin a++; if (fa == 0) fa = i; end
            if (exit_err) begin e++; if (fe == 0) fe = i; end
            if (exit_ack && exit_err) chk("ack_err_overlap", 1, 0);
        end
    endtask

    int g, a, e, fa, fe;

    initial begin
        // reset state
        tick(); tick();
        chk("rst_cap", new_capacity, 0);
        chk("rst_parked", parked, 0);
        chk("rst_empty", empty, 8);
        chk("rst_fee", fee, 0);
        chk("rst_total", time_total, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gate", gate_open, 0);
        chk("rst_strobes", {exit_ack, exit_err}, 0);
        rst = 1'b0;
        tick();

        // happy path: slot 2 = 110 ^ 100
        load_map(8'b0000_0101);
        chk("load_cap", new_capacity, 8'h05);
        chk("load_parked", parked, 2);
        do_exit(3'b110, 3'b100, 8'd10, 8'd25, 1'b0, 8'h00, 0, g, a, e, fa, fe);
        chk("hp_ack_cnt", a, 1);
        chk("hp_ack_lat", fa, 3);
        chk("hp_gate_cyc", g, 4);
        chk("hp_err", e, 0);
        chk("hp_total", time_total, 15);
        chk("hp_fee", fee, 30);
        chk("hp_cap", new_capacity, 8'h01);
        chk("hp_parked", parked, 1);
        chk("hp_empty", empty, 7);
        chk("hp_busy", busy, 0);

        // empty slot 1 = 101 ^ 100; results must hold
        do_exit(3'b101, 3'b100, 8'd0, 8'd100, 1'b0, 8'h00, 0, g, a, e, fa, fe);
        chk("es_err_cnt", e, 1);
        chk("es_err_lat", fe, 2);
        chk("es_ack", a, 0);
        chk("es_gate", g, 0);
        chk("es_cap", new_capacity, 8'h01);
        chk("es_fee", fee, 30);
        chk("es_total", time_total, 15);

        // time wrap, slot 7
        load_map(8'h80);
        do_exit(3'b111, 3'b000, 8'd250, 8'd5, 1'b0, 8'h00, 0, g, a, e, fa, fe);
        chk("tw_ack", a, 1);
        chk("tw_total", time_total, 11);
        chk("tw_fee", fee, 22);
        chk("tw_cap", new_capacity, 8'h00);
        chk("tw_empty", empty, 8);

        // busy ignore: request + FF load during 2nd gate cycle
        load_map(8'h10);
        do_exit(3'b100, 3'b000, 8'd1, 8'd4, 1'b0, 8'h00, 4, g, a, e, fa, fe);
        chk("bi_ack", a, 1);
        chk("bi_err", e, 0);
        chk("bi_gate", g, 4);
        chk("bi_cap", new_capacity, 8'h00);
        chk("bi_fee", fee, 6);

        // simultaneous load + request, slot 3, zero stay
        do_exit(3'b011, 3'b000, 8'd20, 8'd20, 1'b1, 8'h08, 0, g, a, e, fa, fe);
        chk("sl_ack", a, 1);
        chk("sl_err", e, 0);
        chk("sl_cap", new_capacity, 8'h00);
        chk("sl_total", time_total, 0);
        chk("sl_fee", fee, 0);

        // reset asserted in the 2nd gate cycle, between clock edges
        load_map(8'h21);
        token = 3'b000; pattern = 3'b000; time_in = 8'd0; time_out = 8'd3;
        exit_req = 1'b1;
        tick();
        exit_req = 1'b0;
        tick(); tick(); tick();
        chk("mr_gate_before", gate_open, 1);
        #2 rst = 1'b1;
        #1;
        chk("mr_gate", gate_open, 0);
        chk("mr_busy", busy, 0);
        chk("mr_cap", new_capacity, 0);
        chk("mr_parked", parked, 0);
        chk("mr_empty", empty, 8);
        tick();
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
